// File: rtl/fp_pkg.sv
// Shared FP-unit definitions: precision defaults, op encoding and the
// special-operand flag bundle carried alongside every exponent.
package fp_pkg;

    localparam int EXP_W_SP = 8;
    localparam int BIAS_SP  = 127;
    localparam int EXP_W_DP = 11;
    localparam int BIAS_DP  = 1023;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef struct packed {
        logic a_zero;
        logic b_zero;
        logic a_max;
        logic b_max;
    } flags_t;

endpackage

// File: rtl/exp_pipe_if.sv
// Operand and result handshake bundle of the exponent pipe.
interface exp_pipe_if #(
    parameter int EXP_W = 8,
    parameter int TAG_W = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W-1:0]       eA;
    logic [EXP_W-1:0]       eB;
    logic                   op_div;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [EXP_W+1:0] e;
    logic                   ovf;
    logic                   unf;
    logic                   a_zero;
    logic                   b_zero;
    logic                   a_max;
    logic                   b_max;
    logic [TAG_W-1:0]       out_tag;

    modport master (
        output in_valid, eA, eB, op_div, in_tag, out_ready,
        input  in_ready, out_valid, e, ovf, unf, a_zero, b_zero, a_max, b_max, out_tag
    );

    modport slave (
        input  in_valid, eA, eB, op_div, in_tag, out_ready,
        output in_ready, out_valid, e, ovf, unf, a_zero, b_zero, a_max, b_max, out_tag
    );
endinterface

// File: rtl/pipe_stage.sv
// Generic valid/ready register slice; o_ready is the stage's advance term so
// slices chain into a full-throughput pipeline with backpressure.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_vld;
    logic [W-1:0] r_data;
    logic         w_adv;

    assign w_adv = !r_vld || i_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            if (flush) begin
                r_vld <= 1'b0;
            end else if (w_adv) begin
                r_vld <= i_valid;
            end
            if (w_adv) begin
                r_data <= i_data;
            end
        end
    end

    assign o_ready = w_adv;
    assign o_valid = r_vld;
    assign o_data  = r_data;

endmodule

// File: rtl/exp_pipe.sv
// Biased result exponent for FP multiply (eA+eB-BIAS) and divide (eA-eB+BIAS),
// two register slices with range and special-operand flags.
module exp_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_SP,
    parameter int BIAS  = 2**(EXP_W-1)-1,
    parameter int TAG_W = 4
) (
    input  logic     clk,
    input  logic     arst_n,
    input  logic     flush,
    exp_pipe_if.slave bus
);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_X = EW'(BIAS);
    localparam logic signed [EW-1:0] OVF_TH = EW'((2**EXP_W) - 1);
    localparam logic signed [EW-1:0] ZERO_X = '0;

    typedef struct packed {
        logic signed [EW-1:0] a;
        logic signed [EW-1:0] b;
        logic                 op_div;
        logic [TAG_W-1:0]     tag;
        flags_t               flags;
    } s1_t;

    typedef struct packed {
        logic signed [EW-1:0] sum;
        logic                 op_div;
        logic [TAG_W-1:0]     tag;
        flags_t               flags;
    } s2_t;

    function automatic flags_t f_special(input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b);
        flags_t f;
        f.a_zero = (a == '0);
        f.b_zero = (b == '0);
        f.a_max  = &a;
        f.b_max  = &b;
        return f;
    endfunction

    function automatic logic signed [EW-1:0] f_unbias(input logic signed [EW-1:0] sum,
                                                       input logic op);
        return (op == OP_MUL) ? sum - BIAS_X : sum + BIAS_X;
    endfunction

    function automatic logic f_ovf(input logic signed [EW-1:0] x);
        return x >= OVF_TH;
    endfunction

    function automatic logic f_unf(input logic signed [EW-1:0] x);
        return x <= ZERO_X;
    endfunction

    s1_t                  w_pay_p0;
    s1_t                  w_pay_p1;
    s2_t                  w_pay_p1s;
    s2_t                  w_pay_p2;
    logic                 w_vld_p1;
    logic                 w_vld_p2;
    logic                 w_adv2;
    logic signed [EW-1:0] w_b_ext;
    logic signed [EW-1:0] w_e;

    // Stage 1 input: widen both fields; divide folds the subtraction into eB
    always_comb begin
        w_pay_p0        = '0;
        w_b_ext         = signed'({2'b00, bus.eB});
        w_pay_p0.a      = signed'({2'b00, bus.eA});
        w_pay_p0.b      = (bus.op_div == OP_DIV) ? -w_b_ext : w_b_ext;
        w_pay_p0.op_div = bus.op_div;
        w_pay_p0.tag    = bus.in_tag;
        w_pay_p0.flags  = f_special(bus.eA, bus.eB);
    end

    pipe_stage #(.W($bits(s1_t))) u_s1 (
        .clk     (clk),
        .arst_n  (arst_n),
        .flush   (flush),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_pay_p0),
        .o_valid (w_vld_p1),
        .i_ready (w_adv2),
        .o_data  (w_pay_p1)
    );

    // Stage 2 input: two extra bits make the sum overflow-free
    always_comb begin
        w_pay_p1s        = '0;
        w_pay_p1s.sum    = w_pay_p1.a + w_pay_p1.b;
        w_pay_p1s.op_div = w_pay_p1.op_div;
        w_pay_p1s.tag    = w_pay_p1.tag;
        w_pay_p1s.flags  = w_pay_p1.flags;
    end

    pipe_stage #(.W($bits(s2_t))) u_s2 (
        .clk     (clk),
        .arst_n  (arst_n),
        .flush   (flush),
        .i_valid (w_vld_p1),
        .o_ready (w_adv2),
        .i_data  (w_pay_p1s),
        .o_valid (w_vld_p2),
        .i_ready (bus.out_ready),
        .o_data  (w_pay_p2)
    );

    // Output: rebias combinationally; e and range flags read zero when idle
    assign w_e           = f_unbias(w_pay_p2.sum, w_pay_p2.op_div);
    assign bus.out_valid = w_vld_p2;
    assign bus.e         = w_vld_p2 ? w_e : ZERO_X;
    assign bus.ovf       = w_vld_p2 & f_ovf(w_e);
    assign bus.unf       = w_vld_p2 & f_unf(w_e);
    assign bus.a_zero    = w_pay_p2.flags.a_zero;
    assign bus.b_zero    = w_pay_p2.flags.b_zero;
    assign bus.a_max     = w_pay_p2.flags.a_max;
    assign bus.b_max     = w_pay_p2.flags.b_max;
    assign bus.out_tag   = w_pay_p2.tag;

endmodule

// File: tb/tb_exp_pipe.sv
// Scoreboard bench for exp_pipe: directed arithmetic cases, stall stream,
// flush, asynchronous reset and a random handshake burst.
module tb_exp_pipe;
    localparam int EXP_W = 8;
    localparam int TAG_W = 4;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    logic flush  = 1'b0;

    exp_pipe_if #(.EXP_W(EXP_W), .TAG_W(TAG_W)) bus ();

    exp_pipe #(.EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int ovf;
        int unf;
        int flags;
        int tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic exp_t model(input int ea, input int eb, input int op, input int tag);
        exp_t m;
        m.e     = (op != 0) ? ea - eb + 127 : ea + eb - 127;
        m.ovf   = (m.e >= 255) ? 1 : 0;
        m.unf   = (m.e <= 0) ? 1 : 0;
        m.flags = ((ea == 0) ? 8 : 0) + ((eb == 0) ? 4 : 0) + ((ea == 255) ? 2 : 0) + ((eb == 255) ? 1 : 0);
        m.tag   = tag;
        return m;
    endfunction

    function automatic int got_flags();
        return int'({bus.a_zero, bus.b_zero, bus.a_max, bus.b_max});
    endfunction

    // Monitor: handshakes are stable at the falling edge and complete on the next rising edge
    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.in_valid && bus.in_ready && !flush)
                sb.push_back(model(int'(bus.eA), int'(bus.eB), int'(bus.op_div), int'(bus.in_tag)));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", sb.size(), 1);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("sb_e",     int'(bus.e),       x.e);
                    chk("sb_ovf",   int'(bus.ovf),     x.ovf);
                    chk("sb_unf",   int'(bus.unf),     x.unf);
                    chk("sb_flags", got_flags(),       x.flags);
                    chk("sb_tag",   int'(bus.out_tag), x.tag);
                end
            end
            if (!bus.out_valid)
                chk("idle_ovf_unf", int'({bus.ovf, bus.unf}), 0);
        end
    end

    task automatic drive_op(input int ea, input int eb, input int op, input int tag);
        bus.eA     = 8'(ea);
        bus.eB     = 8'(eb);
        bus.op_div = op[0];
        bus.in_tag = 4'(tag);
    endtask

    // Issue one op into an empty pipe and check the 2-cycle latency and its result
    task automatic run_one(input int ea, input int eb, input int op, input int tag,
                           input int xe, input int xo, input int xu, input int xf);
        bus.out_ready = 1'b1;
        drive_op(ea, eb, op, tag);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat1_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat2_valid", int'(bus.out_valid), 1);
        chk("e",     int'(bus.e),       xe);
        chk("ovf",   int'(bus.ovf),     xo);
        chk("unf",   int'(bus.unf),     xu);
        chk("flags", got_flags(),       xf);
        chk("tag",   int'(bus.out_tag), tag);
        @(posedge clk); #1;
    endtask

    task automatic stream5();
        int idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx >= 5 && sb.size() == 0) break;
            bus.out_ready = !(c >= 3 && c <= 6);
            if (idx < 5) begin
                drive_op(20 + idx * 40, 100 + idx * 13, idx % 2, 8 + idx);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2) chk("stream_rdy_c2", int'(bus.in_ready), 1);
            if (c >= 3 && c <= 6) begin
                chk("stall_in_ready", int'(bus.in_ready), 0);
                chk("stall_valid", int'(bus.out_valid), 1);
                if (sb.size() > 0) begin
                    chk("stall_e",   int'(bus.e),       sb[0].e);
                    chk("stall_tag", int'(bus.out_tag), sb[0].tag);
                end
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_issued", idx, 5);
        chk("stream_drained", sb.size(), 0);
    endtask

    task automatic fill_two(input int tag0);
        bus.out_ready = 1'b0;
        drive_op(50, 60, 0, tag0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        drive_op(70, 20, 1, tag0 + 1);
        @(negedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.eA        = '0;
        bus.eB        = '0;
        bus.op_div    = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        #2 arst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_e",         int'(bus.e),         0);
        chk("rst_tag",       int'(bus.out_tag),   0);
        chk("rst_in_ready",  int'(bus.in_ready),  1);
        #10 arst_n = 1'b1;
        @(posedge clk); #1;

        run_one(130, 125, 0, 1,  128, 0, 0, 0);
        run_one(130, 125, 1, 2,  132, 0, 0, 0);
        run_one(1,   254, 1, 3, -126, 0, 1, 0);
        run_one(200, 200, 0, 4,  273, 1, 0, 0);
        run_one(10,  20,  0, 5,  -97, 0, 1, 0);
        run_one(0,   255, 0, 6,  128, 0, 0, 9);

        stream5();

        // Flush with both stages full, then flush an input into an empty pipe
        fill_two(11);
        drive_op(99, 99, 0, 13);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("full_in_ready", int'(bus.in_ready), 0);
        chk("full_valid", int'(bus.out_valid), 1);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_clears", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive_op(33, 44, 0, 7);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_empty_rdy", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_discard", int'(bus.out_valid), 0);
        end
        @(posedge clk); #1;
        run_one(140, 100, 0, 14, 113, 0, 0, 0);

        // Asynchronous reset mid-cycle with two ops in flight
        fill_two(9);
        #3 arst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_e",         int'(bus.e),         0);
        chk("arst_tag",       int'(bus.out_tag),   0);
        chk("arst_flags",     got_flags(),         0);
        chk("arst_ovf_unf",   int'({bus.ovf, bus.unf}), 0);
        sb.delete();
        #7 arst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        chk("arst_idle", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        run_one(100, 27, 1, 15, 200, 0, 0, 0);

        // Random handshake burst checked by the scoreboard
        for (int c = 0; c < 80; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (c < 60 && $urandom_range(0, 2) != 0) begin
                drive_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("final_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exp_pipe.md
Name: exp_pipe

Overview:
- Parametrised, handshaked exponent datapath for the FP multiply/divide unit.
- Computes the biased result exponent: mul is eA+eB-BIAS; div is eA-eB+BIAS.
- Two-stage valid/ready pipeline with backpressure, flush, tag pass-through and range/special flags.
- Sits beside the mantissa multiplier/divider; the tag realigns results in the normaliser.

Parameters:
EXP_W, 8, exponent field width (8 single, 11 double)
BIAS, 2**(EXP_W-1)-1, exponent bias
TAG_W, 4, opaque sideband carried alongside each operation

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all in-flight operations
in_valid  in  1  operand handshake valid
in_ready  out  1  operand handshake ready
eA  in  EXP_W  biased exponent of operand A
eB  in  EXP_W  biased exponent of operand B
op_div  in  1  0 = multiply, 1 = divide
in_tag  in  TAG_W  sideband
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
e  out  EXP_W+2  signed two's-complement result exponent, still biased
ovf  out  1  e >= 2**EXP_W-1
unf  out  1  e <= 0
a_zero, b_zero  out  1  operand exponent field == 0 (denormals flushed)
a_max, b_max  out  1  operand exponent field all ones (inf/NaN)
out_tag  out  TAG_W  sideband of this result

Behaviour:
- Reset (arst_n low, async): both stage valid bits = 0, so out_valid = 0.
  - All data registers and out_tag = 0; in_ready = 1 after release.
- Transfer occurs on a rising edge when valid and ready are both high. Input-side and output-side rules are independent.
- Stage 1 (S1) registers:
  - eA and eB, zero-extended to EXP_W+2 bits.
  - eB is negated in two's complement when op_div = 1.
  - op_div, tag, and the four special flags computed from the raw fields.
- Stage 2 (S2) registers:
  - sum = S1.a + S1.b (EXP_W+2 bits, no truncation possible).
  - Forwarded op_div, tag and flags.
- Output is combinational from S2:
  - e = sum - BIAS when op_div = 0; e = sum + BIAS when op_div = 1.
  - Constant is sign-extended to EXP_W+2 bits.
  - ovf and unf derive from e as signed.
  - ovf and unf are mutually exclusive; both are qualified by out_valid (0 when out_valid = 0).
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 op/cycle.
- Stall/advance rules:
  - adv2 = !v2 | out_ready
  - adv1 = !v1 | adv2
  - in_ready = adv1. This is a combinational path from out_ready; it is permitted.
  - S2 loads from S1 when adv2, with v2 <= v1.
  - S1 loads when adv1, with v1 <= in_valid.
  - Stalled stages hold data and flags unchanged; outputs stay stable while out_valid & !out_ready.
- Capacity is 2 operations. With out_ready low, in_ready drops only once both stages are full.
- flush:
  - Clears v1 and v2 on the next edge. Data registers are don't-care.
  - An input presented in the flush cycle is discarded even if in_ready = 1.
  - flush has priority over all handshakes.
- Special flags are reported, not acted on. e is computed regardless; the normaliser decides the final result.
- Normalisation adjust (+1 mantissa carry) is out of scope; it is applied downstream on e.
- Reset asserted mid-operation: all in-flight ops are lost; no partial output.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W/BIAS defaults for single and double precision.
  - Op encoding constants (OP_MUL = 0, OP_DIV = 1).
  - A packed struct for the flag bundle {a_zero, b_zero, a_max, b_max}.
- One sub-module is natural: pipe_stage, a generic valid/ready register slice parametrised by payload width. It is instantiated twice; arithmetic stays in exp_pipe.

Test Plan:
- Mul, EXP_W = 8, eA = 130, eB = 125, out_ready = 1 -> out_valid 2 cycles later; e = 128, ovf = unf = 0.
- Div, eA = 130, eB = 125 -> e = 132.
- Div, eA = 1, eB = 254 -> e = -126 (10'h382), unf = 1.
- Mul, eA = 200, eB = 200 -> e = 273, ovf = 1.
- Mul, eA = 10, eB = 20 -> e = -97 (10'h39F), unf = 1.
- Mul, eA = 0, eB = 255 -> a_zero = 1, b_max = 1.
- Back-to-back stream of 5 ops, out_ready low for cycles 3-6:
  - in_ready falls after 2 ops are held.
  - e and out_tag remain stable while stalled.
  - All 5 results emerge in order with correct tags; none duplicated or dropped.
- Pipeline full, then flush = 1 for one cycle -> out_valid = 0 the next cycle; a new op issued afterward returns after exactly 2 cycles.
- arst_n pulsed low asynchronously (mid-cycle) with 2 ops in flight:
  - out_valid and all outputs go to 0 immediately.
  - in_ready = 1 after release; a subsequent op computes correctly.
